// File: rtl/fifo_ctrl.sv
// Control FSM for an 8-entry FIFO in front of a single-port-pair RAM: pointers, occupancy,
// threshold flags and RAM strobes, with a sticky error state on overflow/underflow.
module fifo_ctrl #(
    parameter logic [2:0] AF_RST = 3'd6,
    parameter logic [2:0] AE_RST = 3'd1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init,
    input  logic [2:0] th_afull,
    input  logic [2:0] th_aempty,
    input  logic       push,
    input  logic       pop,
    output logic [3:0] state,
    output logic       we_a,
    output logic       re_a,
    output logic [2:0] addr_wa,
    output logic [2:0] addr_ra,
    output logic       rd_valid,
    output logic [3:0] fill,
    output logic       full,
    output logic       empty,
    output logic       almost_full,
    output logic       almost_empty,
    output logic       error
);

    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000,
        ST_ERROR  = 4'b1111
    } state_t;

    state_t     st;
    logic [2:0] afull_th;
    logic [2:0] aempty_th;
    logic [3:0] fill_next;
    logic       operating;
    logic       overflow;
    logic       underflow;
    logic       fault;
    logic       accept_push;
    logic       accept_pop;

    assign state        = st;
    assign full         = (fill == 4'd8);
    assign empty        = (fill == 4'd0);
    assign almost_full  = (fill >= {1'b0, afull_th});
    assign almost_empty = (fill <= {1'b0, aempty_th});
    assign error        = (st == ST_ERROR);

    // Pop-on-empty is an underflow even with a push alongside, so that push is dropped too.
    assign operating   = (st == ST_IDLE) || (st == ST_ACTIVE);
    assign overflow    = operating && push && full && !pop;
    assign underflow   = operating && pop && empty;
    assign fault       = overflow || underflow;
    assign accept_push = operating && push && (!full || pop) && !underflow;
    assign accept_pop  = operating && pop && !empty;
    assign we_a        = accept_push;
    assign re_a        = accept_pop;

    always_comb begin
        // NOTE: default assignment first so this block can never infer a latch.
        fill_next = fill;
        case ({accept_push, accept_pop})
            2'b10:   fill_next = fill + 4'd1;
            2'b01:   fill_next = fill - 4'd1;
            default: fill_next = fill;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= ST_RESET;
            addr_wa   <= 3'd0;
            addr_ra   <= 3'd0;
            fill      <= 4'd0;
            afull_th  <= AF_RST;
            aempty_th <= AE_RST;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= accept_pop;
            fill     <= fill_next;
            if (accept_push) addr_wa <= addr_wa + 3'd1;
            if (accept_pop)  addr_ra <= addr_ra + 3'd1;

            case (st)
                ST_RESET: st <= ST_INIT;
                ST_INIT: begin
                    afull_th  <= th_afull;
                    aempty_th <= th_aempty;
                    if (!init) st <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (fault)                      st <= ST_ERROR;
                    else if (accept_push)           st <= ST_ACTIVE;
                    else if (init && !push && !pop) st <= ST_INIT;
                end
                ST_ACTIVE: begin
                    if (fault)                   st <= ST_ERROR;
                    else if (fill_next == 4'd0)  st <= ST_IDLE;
                end
                ST_ERROR: st <= ST_ERROR;
                // Illegal encodings are treated like a fault and held until reset.
                default:  st <= ST_ERROR;
            endcase
        end
    end

endmodule
